// File: rtl/ppu_scaler_pkg.sv
// Shared defaults, coordinate widths and slot-state encoding for the PPU line scaler.
package ppu_scaler_pkg;

  localparam int SRC_W_DEF      = 256;
  localparam int SRC_H_DEF      = 240;
  localparam int PIX_W_DEF      = 5;
  localparam int NUM_LINES_DEF  = 4;
  localparam int SCALE_LOG2_DEF = 1;
  localparam int H_OFFSET_DEF   = 64;
  localparam int V_OFFSET_DEF   = 0;
  localparam int BORDER_DEF     = 0;

  localparam int SRC_COORD_W  = 9;
  localparam int DISP_COORD_W = 10;
  localparam int TAG_W        = SRC_COORD_W;

  typedef enum logic [1:0] {
    SLOT_EMPTY,
    SLOT_FILLING,
    SLOT_COMPLETE
  } slot_state_t;

endpackage

// File: rtl/line_ram.sv
// Simple dual-port line-buffer RAM: one write port, one registered read port.
module line_ram #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 5,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Read returns the pre-write word on a same-address collision; the output holds when idle.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ppu_line_scaler.sv
// Line-buffered integer upscaler: source lines fill tagged slots, display reads map
// back to source coordinates with a one-cycle registered response.
module ppu_line_scaler
  import ppu_scaler_pkg::*;
#(
  parameter int SRC_W      = SRC_W_DEF,
  parameter int SRC_H      = SRC_H_DEF,
  parameter int PIX_W      = PIX_W_DEF,
  parameter int NUM_LINES  = NUM_LINES_DEF,
  parameter int SCALE_LOG2 = SCALE_LOG2_DEF,
  parameter int H_OFFSET   = H_OFFSET_DEF,
  parameter int V_OFFSET   = V_OFFSET_DEF,
  parameter int BORDER     = BORDER_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    frame_start,
  input  logic                    pix_valid,
  input  logic [SRC_COORD_W-1:0]  pix_x,
  input  logic [SRC_COORD_W-1:0]  pix_y,
  input  logic [PIX_W-1:0]        pix_data,
  input  logic                    rd_en,
  input  logic [DISP_COORD_W-1:0] rd_x,
  input  logic [DISP_COORD_W-1:0] rd_y,
  input  logic                    scanline_mode,
  output logic                    rd_valid,
  output logic [PIX_W-1:0]        rd_data,
  output logic                    rd_border,
  output logic                    rd_dim,
  output logic                    underrun
);

  localparam int SLOT_W = $clog2(NUM_LINES);
  localparam int DEPTH  = NUM_LINES * SRC_W;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CW     = DISP_COORD_W + 1;

  localparam logic [CW-1:0]          SRC_W_C    = CW'(SRC_W);
  localparam logic [CW-1:0]          SRC_H_C    = CW'(SRC_H);
  localparam logic [CW-1:0]          H_OFF_C    = CW'(H_OFFSET);
  localparam logic [CW-1:0]          V_OFF_C    = CW'(V_OFFSET);
  localparam logic [CW-1:0]          PHASE_MASK = CW'((1 << SCALE_LOG2) - 1);
  localparam logic [SRC_COORD_W-1:0] LAST_X     = SRC_COORD_W'(SRC_W - 1);
  localparam logic [PIX_W-1:0]       BORDER_PIX = PIX_W'(BORDER);

  // Write side: acceptance, slot selection and RAM address.
  logic              wr_ok;
  logic [SLOT_W-1:0] wr_slot;
  logic [ADDR_W-1:0] wr_addr;

  assign wr_ok   = pix_valid && ({1'b0, pix_x} < SRC_W_C[SRC_COORD_W:0])
                             && ({1'b0, pix_y} < SRC_H_C[SRC_COORD_W:0]);
  assign wr_slot = pix_y[SLOT_W-1:0];
  assign wr_addr = ADDR_W'(32'(wr_slot) * 32'(SRC_W) + 32'(pix_x));

  slot_state_t      slot_state [NUM_LINES];
  slot_state_t      state_nxt  [NUM_LINES];
  logic [TAG_W-1:0] slot_tag   [NUM_LINES];
  logic [TAG_W-1:0] tag_nxt    [NUM_LINES];

  // frame_start clears first so a coincident pix_x=0 write still opens its slot.
  always_comb begin
    for (int i = 0; i < NUM_LINES; i++) begin
      state_nxt[i] = frame_start ? SLOT_EMPTY : slot_state[i];
      tag_nxt[i]   = slot_tag[i];
    end
    if (wr_ok) begin
      if (pix_x == '0) begin
        state_nxt[wr_slot] = SLOT_FILLING;
        tag_nxt[wr_slot]   = pix_y;
      end else if (pix_x == LAST_X && state_nxt[wr_slot] == SLOT_FILLING
                   && slot_tag[wr_slot] == pix_y) begin
        state_nxt[wr_slot] = SLOT_COMPLETE;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        slot_state[i] <= SLOT_EMPTY;
        slot_tag[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LINES; i++) begin
        slot_state[i] <= state_nxt[i];
        slot_tag[i]   <= tag_nxt[i];
      end
    end
  end

  // Read mapping (stage p0): one extra bit so offsets below the origin never wrap.
  logic [CW-1:0]     dx, dy, sx, sy;
  logic              x_in, y_in, active, hit, dim;
  logic [SLOT_W-1:0] rd_slot;
  logic [ADDR_W-1:0] rd_addr;

  assign x_in    = {1'b0, rd_x} >= H_OFF_C;
  assign y_in    = {1'b0, rd_y} >= V_OFF_C;
  assign dx      = {1'b0, rd_x} - H_OFF_C;
  assign dy      = {1'b0, rd_y} - V_OFF_C;
  assign sx      = dx >> SCALE_LOG2;
  assign sy      = dy >> SCALE_LOG2;
  assign active  = x_in && y_in && (sx < SRC_W_C) && (sy < SRC_H_C);
  assign rd_slot = sy[SLOT_W-1:0];
  assign rd_addr = ADDR_W'(32'(rd_slot) * 32'(SRC_W) + 32'(sx));
  assign hit     = active && slot_state[rd_slot] == SLOT_COMPLETE
                          && slot_tag[rd_slot] == sy[TAG_W-1:0];
  assign dim     = scanline_mode && active && (SCALE_LOG2 > 0)
                                 && ((dy & PHASE_MASK) == PHASE_MASK);

  logic [PIX_W-1:0] ram_q;

  line_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (PIX_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock   (clock),
    .wr_en   (wr_ok),
    .wr_addr (wr_addr),
    .wr_data (pix_data),
    .rd_en   (rd_en && active),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

  // Response (stage p1): flags only move on an accepted request so they hold between reads.
  logic vld_p1, hit_p1, border_p1, dim_p1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      hit_p1    <= 1'b0;
      border_p1 <= 1'b0;
      dim_p1    <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      vld_p1 <= rd_en;
      if (rd_en) begin
        hit_p1    <= hit;
        border_p1 <= !active;
        dim_p1    <= dim;
      end
      if (rd_en && active && !hit) underrun <= 1'b1;
      else if (frame_start)        underrun <= 1'b0;
    end
  end

  assign rd_valid  = vld_p1;
  assign rd_data   = hit_p1 ? ram_q : BORDER_PIX;
  assign rd_border = border_p1;
  assign rd_dim    = dim_p1;

endmodule

// File: doc/ppu_line_scaler.md
PPU_LINE_SCALER -- requirements
Module: ppu_line_scaler

Interface
REQ-001 SHALL have parameter SRC_W, default 256: source pixels per line.
REQ-002 SHALL have parameter SRC_H, default 240: source lines per frame.
REQ-003 SHALL have parameter PIX_W, default 5: palette-index width.
REQ-004 SHALL have parameter NUM_LINES, default 4: line-buffer slots; power of 2, at least 2.
REQ-005 SHALL have parameter SCALE_LOG2, default 1: integer upscale is 2^SCALE_LOG2, range 0..2.
REQ-006 SHALL have parameters H_OFFSET, default 64, and V_OFFSET, default 0: active-window origin in display pixels.
REQ-007 SHALL have parameter BORDER, default 0: PIX_W index output outside the window or on underrun.
REQ-008 SHALL have port clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-009 SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-010 SHALL have port frame_start, input, 1 bit: one-cycle pulse marking a new source frame.
REQ-011 SHALL have ports pix_valid (in, 1), pix_x (in, 9), pix_y (in, 9) and pix_data (in, PIX_W): the source pixel write strobe and its coordinates/index.
REQ-012 SHALL have ports rd_en (in, 1), rd_x (in, 10) and rd_y (in, 10): the display pixel request.
REQ-013 SHALL have port scanline_mode, input, 1 bit: enables the dim flag.
REQ-014 SHALL have ports rd_valid (out, 1), rd_data (out, PIX_W), rd_border (out, 1) and rd_dim (out, 1): the read response.
REQ-015 SHALL have port underrun, output, 1 bit: sticky flag for a read of a line that is not ready.

Function
REQ-016 Write acceptance: a write SHALL occur only when pix_valid=1, pix_x<SRC_W and pix_y<SRC_H; out-of-range writes SHALL be ignored with no state change.
REQ-017 An accepted write SHALL store pix_data into slot s=pix_y mod NUM_LINES, entry pix_x.
REQ-018 Each slot SHALL hold a tag (9 bit) and a state: EMPTY, FILLING or COMPLETE.
REQ-019 Slot state transitions SHALL be:
- accepted write with pix_x=0: slot goes to FILLING, tag=pix_y, from any state;
- accepted write with pix_x=SRC_W-1 into a FILLING slot whose tag equals pix_y: slot goes to COMPLETE;
- frame_start: every slot goes to EMPTY.
REQ-020 When frame_start and an accepted write coincide, frame_start SHALL apply first and the write's transition SHALL then apply.
REQ-021 Read mapping SHALL compute dx=rd_x-H_OFFSET, dy=rd_y-V_OFFSET, sx=dx>>SCALE_LOG2, sy=dy>>SCALE_LOG2.
REQ-022 The request SHALL be active iff rd_x>=H_OFFSET, rd_y>=V_OFFSET, sx<SRC_W and sy<SRC_H.
REQ-023 Read latency SHALL be exactly 1 cycle: rd_valid is rd_en registered, and rd_data, rd_border and rd_dim SHALL update only with rd_valid=1 and hold otherwise.
REQ-024 Inactive request: rd_data=BORDER, rd_border=1, rd_dim=0.
REQ-025 Active request hitting slot sy mod NUM_LINES with state COMPLETE and tag=sy: rd_data=stored entry sx, rd_border=0.
REQ-026 Active request not meeting REQ-025: rd_data=BORDER, rd_border=0, and underrun SHALL be set in the response cycle.
REQ-027 rd_dim SHALL be 1 iff scanline_mode=1, the request is active, SCALE_LOG2>0, and dy[SCALE_LOG2-1:0] is all ones.
REQ-028 A read and a write to the same slot/entry in the same cycle SHALL return the pre-write contents.
REQ-029 underrun SHALL stay set until frame_start or reset; if frame_start and a new underrun coincide, underrun SHALL be set.
REQ-030 All coordinate arithmetic SHALL be unsigned, computed one bit wider than its inputs so that a negative difference is detected as inactive and never wraps.

Reset
REQ-031 While reset=1: all slots EMPTY, tags 0, rd_valid=0, rd_data=BORDER, rd_border=0, rd_dim=0, underrun=0.
REQ-032 Line-buffer contents SHALL NOT be reset; they SHALL be unobservable until rewritten, because slots are EMPTY.
REQ-033 Reset asserted mid-line SHALL abandon that fill; later pixels of the same line without pix_x=0 SHALL NOT complete the slot.

Structure
REQ-034 Package ppu_scaler_pkg SHALL hold the parameter defaults, the slot-state enum (EMPTY/FILLING/COMPLETE) and the coordinate widths.
REQ-035 Sub-module line_ram SHALL be a simple dual-port RAM (1 write, 1 registered read) of depth NUM_LINES*SRC_W and width PIX_W; all tag, state and mapping logic SHALL sit in ppu_line_scaler.

Verification
REQ-036 Defaults, fill line 0 with pix_data=x[4:0], then rd_en at (64,0) and (67,1) -> rd_valid next cycle, rd_data=0 then 1, rd_border=0, rd_dim 0 then 0 (scanline_mode=0).
REQ-037 scanline_mode=1, line 0 complete, read (64,1) -> rd_dim=1; read (64,0) -> rd_dim=0; read (10,0) -> rd_data=BORDER, rd_border=1, rd_dim=0.
REQ-038 Line 5 written up to x=100 only, read (64,10) -> rd_data=BORDER, rd_border=0, underrun=1 and held; frame_start -> underrun=0.
REQ-039 Write lines 0..4 fully (NUM_LINES=4), read (64,0) -> underrun (slot 0 tag=4); read (64,8) -> line-4 data.
REQ-040 frame_start coincident with a pix_x=0 write of line 7 -> slot 3 FILLING with tag 7, all other slots EMPTY; assert reset mid-line, resume at x=10..255 -> read of that line underruns.
